dmem_arbiter: RTL and testbench

//  Shares the word-organised data memory (4 byte lanes, word-indexed, negedge write,

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_arbiter_byte_merge.sv | 18 +
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_pkg;

    localparam int NUM_MASTERS = 2;
    localparam logic [3:0] BE_FULL = 4'hF;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    typedef enum logic [$clog2(NUM_MASTERS)-1:0] {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

endpackage

// File: rtl/dmem_arbiter_byte_merge.sv
// Combinational lane merge used to turn a partial-word store into a full-word write.
module byte_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   merged
);

    always_comb begin
        merged = rdata;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two masters onto a word-wide memory; partial stores become read-modify-write.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter bit RR_EN  = 1'b1,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [31:0]         m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_be,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [31:0]         m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_be,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                mem_wen,
    output logic                mem_ren,
    output logic [31:0]         mem_addr,
    output logic [DATA_W-1:0]   mem_data_i,
    input  logic [DATA_W-1:0]   mem_data_o
);

    state_t              state;
    master_t             owner;
    master_t             last_grant;
    master_t             pick;
    logic                lat_we;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W/8-1:0] lat_be;
    logic [DATA_W-1:0]   rdata;
    logic [DATA_W-1:0]   merged;

    logic                sel_we;
    logic [29:0]         sel_word;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_be;

    // Byte offset bits never reach the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

    assign m0_rdata = rdata;
    assign m1_rdata = rdata;

    byte_merge #(.DATA_W(DATA_W)) u_merge (
        .wdata  (lat_wdata),
        .rdata  (mem_data_o),
        .be     (lat_be),
        .merged (merged)
    );

    // On contention the round-robin pointer favours whoever did not win last time.
    always_comb begin
        pick = M0;
        if (m0_req && m1_req) begin
            pick = (RR_EN && last_grant == M0) ? M1 : M0;
        end else if (m1_req) begin
            pick = M1;
        end
        sel_we    = (pick == M1) ? m1_we          : m0_we;
        sel_word  = (pick == M1) ? m1_addr[31:2]  : m0_addr[31:2];
        sel_wdata = (pick == M1) ? m1_wdata       : m0_wdata;
        sel_be    = (pick == M1) ? m1_be          : m0_be;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= M0;
            last_grant <= M1;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            rdata      <= '0;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            mem_wen    <= 1'b0;
            mem_ren    <= 1'b0;
            mem_addr   <= '0;
            mem_data_i <= '0;
        end else begin
            m0_gnt <= 1'b0;
            m1_gnt <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner      <= pick;
                        last_grant <= pick;
                        lat_we     <= sel_we;
                        lat_wdata  <= sel_wdata;
                        lat_be     <= sel_be;
                        m0_gnt     <= (pick == M0);
                        m1_gnt     <= (pick == M1);
                        if (!sel_we || (sel_be != BE_FULL && sel_be != '0)) begin
                            state    <= RD;
                            mem_ren  <= 1'b1;
                            mem_addr <= {sel_word, 2'b00};
                        end else if (sel_be == BE_FULL) begin
                            state      <= WR;
                            mem_wen    <= 1'b1;
                            mem_addr   <= {sel_word, 2'b00};
                            mem_data_i <= sel_wdata;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RD: begin
                    mem_ren <= 1'b0;
                    if (lat_we) begin
                        state      <= WR;
                        mem_wen    <= 1'b1;
                        mem_data_i <= merged;
                    end else begin
                        state     <= RESP;
                        mem_addr  <= '0;
                        rdata     <= mem_data_o;
                        m0_rvalid <= (owner == M0);
                        m1_rvalid <= (owner == M1);
                    end
                end
                WR: begin
                    state      <= RESP;
                    mem_wen    <= 1'b0;
                    mem_addr   <= '0;
                    mem_data_i <= '0;
                    rdata      <= '0;
                    m0_rvalid  <= (owner == M0);
                    m1_rvalid  <= (owner == M1);
                end
                RESP: begin
                    // A zero-enable store enters here without rvalid; it spends one
                    // extra cycle so its response lands at the same latency as a full write.
                    if (m0_rvalid || m1_rvalid) begin
                        state     <= IDLE;
                        m0_rvalid <= 1'b0;
                        m1_rvalid <= 1'b0;
                        rdata     <= '0;
                    end else begin
                        rdata     <= '0;
                        m0_rvalid <= (owner == M0);
                        m1_rvalid <= (owner == M1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a word-array reference.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [3:0]  m0_be = 0, m1_be = 0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_wen, mem_ren;
    logic [31:0] mem_addr, mem_data_i, mem_data_o;

    logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_mem_wen, fp_mem_ren;
    logic [31:0] fp_mem_addr, fp_mem_data_i;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        pre_we = 0;
    logic [9:0]  pre_idx = 0;
    logic [31:0] pre_data = 0;

    int tests_run = 0;
    int tests_failed = 0;
    int both_en_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.RR_EN(1'b1), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o)
    );

    dmem_arbiter #(.RR_EN(1'b0), .DATA_W(32)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
        .mem_wen(fp_mem_wen), .mem_ren(fp_mem_ren), .mem_addr(fp_mem_addr),
        .mem_data_i(fp_mem_data_i), .mem_data_o(32'h0)
    );

    // Word memory: combinational read, negedge write, plus a bench-side preload port.
    assign mem_data_o = mem[mem_addr[11:2]];
    always @(negedge clk) begin
        if (mem_wen) mem[mem_addr[11:2]] <= mem_data_i;
        else if (pre_we) mem[pre_idx] <= pre_data;
        if (mem_wen && mem_ren) both_en_cnt <= both_en_cnt + 1;
    end

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        pre_idx = idx; pre_data = data; pre_we = 1'b1;
        @(negedge clk); #1;
        pre_we = 1'b0;
        ref_mem[idx] = data;
    endtask

    // Reference write rule: enabled lanes take new data, others keep the old word.
    task automatic model_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        ref_mem[addr[11:2]] = (ref_mem[addr[11:2]] & ~mask) | (wdata & mask);
    endtask

    task automatic do_access(input bit mst, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             output int gnt_cyc, output int rv_cyc, output logic [31:0] rd,
                             output bit saw_wen, output bit saw_ren, output bit other_pulse,
                             output logic [31:0] seen_addr);
        gnt_cyc = -1; rv_cyc = -1; rd = '0;
        saw_wen = 0; saw_ren = 0; other_pulse = 0; seen_addr = '0;
        @(posedge clk); #1;
        if (!mst) begin
            m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
        end else begin
            m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
        end
        @(posedge clk);
        for (int c = 1; c <= 8 && rv_cyc < 0; c++) begin
            @(negedge clk);
            if ((mst ? m1_gnt : m0_gnt) && gnt_cyc < 0) begin
                gnt_cyc = c;
                m0_req = 0; m1_req = 0;
            end
            if (mst ? (m0_gnt || m0_rvalid) : (m1_gnt || m1_rvalid)) other_pulse = 1;
            if (mem_wen) saw_wen = 1;
            if (mem_ren) saw_ren = 1;
            if (mem_wen || mem_ren) seen_addr = mem_addr;
            if (mst ? m1_rvalid : m0_rvalid) begin
                rv_cyc = c;
                rd = mst ? m1_rdata : m0_rdata;
            end
        end
        m0_req = 0; m1_req = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wen, mem_ren} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wen, mem_ren});
        end
        tests_run++;
        if ({mem_addr, mem_data_i, m0_rdata, m1_rdata} !== 128'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: addr=%h data_i=%h rdata=%h expected all 0",
                     mem_addr, mem_data_i, m0_rdata);
        end
        rst = 0;
    endtask

    task automatic test_full_write_read();
        int g, r; logic [31:0] rd, sa; bit sw, sr, op;
        do_access(0, 1, 32'h100, 32'hDEADBEEF, 4'hF, g, r, rd, sw, sr, op, sa);
        model_write(32'h100, 32'hDEADBEEF, 4'hF);
        tests_run++;
        if (g !== 1 || r !== 2) begin
            tests_failed++;
            $display("[TB] FAIL full_write_latency: gnt@%0d rvalid@%0d expected gnt@1 rvalid@2", g, r);
        end
        tests_run++;
        if (sw !== 1 || sr !== 0 || rd !== 32'h0 || op !== 0) begin
            tests_failed++;
            $display("[TB] FAIL full_write_bus: wen=%0d ren=%0d rdata=%h other=%0d expected 1 0 0 0", sw, sr, rd, op);
        end
        do_access(0, 0, 32'h100, 32'h0, 4'h0, g, r, rd, sw, sr, op, sa);
        tests_run++;
        if (g !== 1 || r !== 2 || rd !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL full_read: gnt@%0d rvalid@%0d rdata=%h expected 1 2 deadbeef", g, r, rd);
        end
    endtask

    task automatic test_partial_write();
        int g, r; logic [31:0] rd, sa; bit sw, sr, op;
        preload(10'h080, 32'h11223344);
        do_access(1, 1, 32'h200, 32'hAABBCCDD, 4'b0101, g, r, rd, sw, sr, op, sa);
        model_write(32'h200, 32'hAABBCCDD, 4'b0101);
        tests_run++;
        if (g !== 1 || r !== 3 || sw !== 1 || sr !== 1 || op !== 0) begin
            tests_failed++;
            $display("[TB] FAIL partial_write: gnt@%0d rvalid@%0d wen=%0d ren=%0d other=%0d expected 1 3 1 1 0",
                     g, r, sw, sr, op);
        end
        do_access(1, 0, 32'h200, 32'h0, 4'hF, g, r, rd, sw, sr, op, sa);
        tests_run++;
        if (rd !== 32'h11BB33DD || rd !== ref_mem[10'h080]) begin
            tests_failed++;
            $display("[TB] FAIL partial_merge: got %h expected 11bb33dd", rd);
        end
    endtask

    task automatic test_arbitration();
        int rr_q[$]; int fp_q[$]; int fp_m1 = 0; int both = 0;
        rst = 1; @(posedge clk); @(negedge clk); rst = 0;
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h800;
        m1_req = 1; m1_we = 0; m1_addr = 32'h804;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (m0_gnt) rr_q.push_back(0);
            if (m1_gnt) rr_q.push_back(1);
            if (fp_m0_gnt) fp_q.push_back(0);
            if (fp_m1_gnt) fp_q.push_back(1);
            if ((m0_gnt && m1_gnt) || (fp_m0_gnt && fp_m1_gnt)) both++;
        end
        tests_run++;
        if (rr_q.size() < 4 || rr_q[0] !== 0 || rr_q[1] !== 1 || rr_q[2] !== 0 || rr_q[3] !== 1) begin
            tests_failed++;
            $display("[TB] FAIL rr_order: got %p expected starting 0,1,0,1", rr_q);
        end
        tests_run++;
        if (fp_q.size() < 4 || fp_q.sum() != 0) begin
            tests_failed++;
            $display("[TB] FAIL fixed_prio: got %p expected at least 4 grants all m0", fp_q);
        end
        m0_req = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (fp_m1_gnt) fp_m1++;
            if ((m0_gnt && m1_gnt) || (fp_m0_gnt && fp_m1_gnt)) both++;
        end
        m1_req = 0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (fp_m1 < 1 || both !== 0) begin
            tests_failed++;
            $display("[TB] FAIL fixed_prio_release: m1 grants=%0d double=%0d expected >=1 and 0", fp_m1, both);
        end
    endtask

    task automatic test_zero_be_write();
        int g, r; logic [31:0] rd, sa; bit sw, sr, op;
        preload(10'h0C0, 32'h55);
        do_access(0, 1, 32'h300, 32'hFFFFFFFF, 4'h0, g, r, rd, sw, sr, op, sa);
        tests_run++;
        if (g !== 1 || r !== 2 || sw !== 0 || sr !== 0) begin
            tests_failed++;
            $display("[TB] FAIL zero_be: gnt@%0d rvalid@%0d wen=%0d ren=%0d expected 1 2 0 0", g, r, sw, sr);
        end
        @(negedge clk);
        tests_run++;
        if (mem[10'h0C0] !== 32'h55) begin
            tests_failed++;
            $display("[TB] FAIL zero_be_mem: got %h expected 00000055", mem[10'h0C0]);
        end
    endtask

    task automatic test_reset_mid_op();
        bit saw_rv = 0, saw_wen = 0;
        preload(10'h140, 32'h12345678);
        @(posedge clk); #1;
        m1_req = 1; m1_we = 1; m1_addr = 32'h500; m1_wdata = 32'hA5A5A5A5; m1_be = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (m1_gnt !== 1 || mem_ren !== 1) begin
            tests_failed++;
            $display("[TB] FAIL rmw_rd_phase: gnt=%0d ren=%0d expected 1 1", m1_gnt, mem_ren);
        end
        m1_req = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            if (m1_rvalid || m0_rvalid) saw_rv = 1;
            if (mem_wen) saw_wen = 1;
            @(negedge clk);
        end
        tests_run++;
        if (saw_rv || saw_wen || mem[10'h140] !== 32'h12345678) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_op: rvalid=%0d wen=%0d mem=%h expected 0 0 12345678",
                     saw_rv, saw_wen, mem[10'h140]);
        end
    endtask

    task automatic test_unaligned_read();
        int g, r; logic [31:0] rd, sa; bit sw, sr, op;
        preload(10'h041, 32'hCAFEF00D);
        do_access(0, 0, 32'h107, 32'h0, 4'h1, g, r, rd, sw, sr, op, sa);
        tests_run++;
        if (sa !== 32'h104 || rd !== 32'hCAFEF00D || r !== 2) begin
            tests_failed++;
            $display("[TB] FAIL unaligned_read: addr=%h rdata=%h rvalid@%0d expected 104 cafef00d 2", sa, rd, r);
        end
    endtask

    task automatic test_random();
        int g, r; logic [31:0] rd, sa, addr, wd, exp_rd; bit sw, sr, op, mst, we;
        logic [3:0] be; int exp_rv;
        for (int i = 0; i < 16; i++) preload(10'h200 + 10'(i), $urandom);
        for (int n = 0; n < 40; n++) begin
            mst  = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = 32'h800 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            exp_rd = we ? 32'h0 : ref_mem[addr[11:2]];
            exp_rv = (we && be != 4'hF && be != 4'h0) ? 3 : 2;
            do_access(mst, we, addr, wd, be, g, r, rd, sw, sr, op, sa);
            if (we) model_write(addr, wd, be);
            tests_run++;
            if (g !== 1 || r !== exp_rv || op !== 0) begin
                tests_failed++;
                $display("[TB] FAIL rand_timing[%0d]: gnt@%0d rvalid@%0d other=%0d expected 1 %0d 0",
                         n, g, r, op, exp_rv);
            end
            tests_run++;
            if (rd !== exp_rd) begin
                tests_failed++;
                $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", n, rd, exp_rd);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (mem[10'h200 + 10'(i)] !== ref_mem[10'h200 + 10'(i)]) begin
                tests_failed++;
                $display("[TB] FAIL rand_mem[%0d]: got %h expected %h", i,
                         mem[10'h200 + 10'(i)], ref_mem[10'h200 + 10'(i)]);
            end
        end
        tests_run++;
        if (both_en_cnt !== 0) begin
            tests_failed++;
            $display("[TB] FAIL ren_wen_exclusive: got %0d overlaps expected 0", both_en_cnt);
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_arbitration();
        test_zero_be_write();
        test_reset_mid_op();
        test_unaligned_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
